// File: rtl/truth_table_sequencer.sv
// Exhaustive 4-input sweep generator and checker for y = a&~b | c&~d.
// Each vector is held DWELL cycles; y_in is sampled on the last cycle of the dwell.
module truth_table_sequencer #(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [4:0] err_count,
  output logic [3:0] fail_idx
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] vec_idx_q, vec_idx_d;
  logic       a_q, b_q, c_q, d_q;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch_q, mismatch_d;
  logic [4:0] err_count_q, err_count_d;
  logic [3:0] fail_idx_q, fail_idx_d;
  logic       y_exp;

  // Golden response for the vector currently on the stimulus pins.
  assign y_exp = (a_q & ~b_q) | (c_q & ~d_q);

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    vec_idx_d   = vec_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    mismatch_d  = 1'b0;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          dwell_d     = 8'd0;
          vec_idx_d   = 4'd0;
          err_count_d = 5'd0;
          fail_idx_d  = 4'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      RUN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          if (y_in != y_exp) begin
            mismatch_d = 1'b1;
            if (err_count_q != 5'd16) err_count_d = err_count_q + 5'd1;
            if (err_count_q == 5'd0)  fail_idx_d  = vec_idx_q;
          end
          if (vec_idx_q == 4'd15) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == 5'd0);
          end else begin
            vec_idx_d = vec_idx_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle.
        state_d     = IDLE;
        dwell_d     = 8'd0;
        vec_idx_d   = 4'd0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        err_count_d = 5'd0;
        fail_idx_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dwell_q     <= 8'd0;
      vec_idx_q   <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      d_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= 5'd0;
      fail_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      vec_idx_q   <= vec_idx_d;
      // Stimulus pins are a registered copy of the next index, so they track vec_idx exactly.
      a_q         <= vec_idx_d[3];
      b_q         <= vec_idx_d[2];
      c_q         <= vec_idx_d[1];
      d_q         <= vec_idx_d[0];
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
  assign fail_idx  = fail_idx_q;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have one parameter: DWELL, default 10, clock cycles each input vector is held (legal 2..255).
REQ-002 The block SHALL have the following ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to run one full 16-vector sweep.
- y_in  input  1  response of the downstream y = a·b' + c·d' logic under test.
- a, b, c, d  output  1 each  stimulus to the logic under test.
- vec_idx  output  4  current vector index.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; holds until next start or reset.
- pass  output  1  valid while done: 1 = zero mismatches.
- mismatch  output  1  one-cycle pulse per failing vector.
- err_count  output  5  number of failing vectors, 0..16.
- fail_idx  output  4  index of first failing vector; valid when err_count != 0.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 IDLE -> RUN: on a clk edge with start=1. vec_idx, the dwell counter, err_count and fail_idx clear on that edge. busy=1 from the following cycle.
REQ-006 Stimulus mapping SHALL be a=vec_idx[3], b=vec_idx[2], c=vec_idx[1], d=vec_idx[0]. The sweep runs vec_idx 0 to 15 ascending (a is MSB, d is LSB).
REQ-007 In RUN, each vector SHALL be driven for exactly DWELL consecutive cycles. An 8-bit dwell counter counts 0..DWELL-1.
REQ-008 y_in SHALL be sampled on the edge where the dwell counter = DWELL-1. On that same edge vec_idx increments (if < 15) and the dwell counter returns to 0.
REQ-009 The expected value SHALL be (a & ~b) | (c & ~d), computed from the currently driven vector.
REQ-010 On a sample edge where y_in != expected:
- mismatch=1 for exactly the next cycle.
- err_count increments on that edge.
- If err_count was 0, fail_idx loads the current vec_idx. fail_idx is not updated by later mismatches.
REQ-011 err_count SHALL never wrap; the maximum reachable value is 16.
REQ-012 RUN -> DONE: on the sample edge of vec_idx=15. In DONE: busy=0, done=1, pass=(err_count==0); vec_idx holds 15 and a,b,c,d hold 1,1,1,1.
REQ-013 The total busy duration SHALL be exactly 16*DWELL cycles.
REQ-014 start SHALL be ignored while in RUN.
REQ-015 start in DONE SHALL behave exactly as start in IDLE: done and pass clear on that edge and a new sweep begins.
REQ-016 No state other than IDLE, RUN and DONE SHALL be reachable. Illegal encodings SHALL return to IDLE.

Reset
REQ-017 When rst_n=0, the block SHALL immediately, independent of clk:
- enter IDLE;
- drive all outputs to 0: a, b, c, d, vec_idx, busy, done, pass, mismatch, err_count, fail_idx;
- clear the dwell counter.
REQ-018 Reset asserted mid-sweep SHALL abandon the sweep with no residual state. The first start after reset release begins at vec_idx=0.
REQ-019 With rst_n=1, the block SHALL leave IDLE only on start=1.

Verification
REQ-020 Correct model: DWELL=4, y_in driven by a correct combinational model, one-cycle start -> busy high 64 cycles, then done=1, pass=1, err_count=0, mismatch never asserted.
REQ-021 Stuck-at-0: y_in tied 0, DWELL=4 -> err_count=7, fail_idx=2, pass=0, seven mismatch pulses at vec_idx 2, 6, 8, 9, 10, 11, 14.
REQ-022 Stuck-at-1: y_in tied 1, DWELL=2 -> err_count=9, fail_idx=0, pass=0, each mismatch pulse exactly 1 cycle wide.
REQ-023 Reset mid-sweep: rst_n pulsed low while vec_idx=5 -> all outputs 0 without waiting for a clk edge; next start sweeps from vec_idx=0 and ends with the correct err_count.
REQ-024 Start handling: start held high for the entire sweep -> exactly one sweep, duration 16*DWELL. A start pulse in DONE -> done=0 on the next cycle, err_count=0, new sweep runs.
